// File: rtl/regex_stream_pkg.sv
// regex_stream_pkg: shared types and defaults for the regex stream driver
package regex_stream_pkg;
  localparam int POS_W_DEF = 32;
  typedef enum logic [1:0] {IDLE, RESTART, WAIT_RDY, EMIT} state_t;
  typedef struct packed {
    logic       last;
    logic [7:0] chr;
  } entry_t;
endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: small synchronous FIFO with full/empty flags and a show-ahead head
module byte_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr,
  input  logic [W-1:0] wdata,
  input  logic         rd,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  // extra pointer bit tells full from empty when the indices coincide
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign empty = wp == rp;
  assign rdata = mem[rp[AW-1:0]];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr && !full) wp <= wp + 1'b1;
      if (rd && !empty) rp <= rp + 1'b1;
    end
  always_ff @(posedge clk)
    if (wr && !full) mem[wp[AW-1:0]] <= wdata;
endmodule

// File: rtl/regex_stream_driver.sv
// regex_stream_driver: buffers a byte stream and sequences one matcher evaluation per character
module regex_stream_driver
  import regex_stream_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int POS_W          = POS_W_DEF,
  parameter int RESTART_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_char,
  input  logic             in_last,
  output logic             rx_reset,
  output logic [7:0]       rx_char,
  output logic             rx_last,
  input  logic             rx_rdy,
  input  logic             rx_match,
  input  logic [POS_W-1:0] rx_start,
  input  logic [POS_W-1:0] rx_end,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [POS_W-1:0] res_start,
  output logic [POS_W-1:0] res_end,
  output logic             res_last,
  output logic             done,
  output logic [POS_W-1:0] char_count
);
  localparam int CW = $clog2(RESTART_CYCLES + 1);
  state_t          state;
  entry_t          head;
  logic            full, empty, pop, ready_en, first;
  logic [CW-1:0]   cnt;
  assign in_ready = ready_en && !full;
  assign pop      = (state == IDLE) && !empty;
  byte_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(entry_t))) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (in_valid && in_ready),
    .wdata ({in_last, in_char}),
    .rd    (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );
  // first WAIT_RDY cycle ignores rx_rdy: it may still reflect the previous evaluation
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state      <= IDLE;
      ready_en   <= 1'b0;
      rx_reset   <= 1'b1;
      rx_char    <= '0;
      rx_last    <= 1'b0;
      cnt        <= '0;
      first      <= 1'b0;
      res_valid  <= 1'b0;
      res_start  <= '0;
      res_end    <= '0;
      res_last   <= 1'b0;
      done       <= 1'b0;
      char_count <= '0;
    end else begin
      ready_en <= 1'b1;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          rx_reset <= pop;
          cnt      <= '0;
          if (pop) begin
            rx_char <= head.chr;
            rx_last <= head.last;
            state   <= RESTART;
          end
        end
        RESTART: begin
          cnt   <= cnt + 1'b1;
          first <= 1'b1;
          if (cnt == CW'(RESTART_CYCLES - 1)) begin
            rx_reset <= 1'b0;
            state    <= WAIT_RDY;
          end
        end
        WAIT_RDY: begin
          first <= 1'b0;
          if (!first && rx_rdy) begin
            if (rx_match) begin
              res_valid <= 1'b1;
              res_start <= rx_start;
              res_end   <= rx_end;
              res_last  <= rx_last;
              state     <= EMIT;
            end else begin
              done       <= rx_last;
              char_count <= rx_last ? '0 : char_count + 1'b1;
              state      <= IDLE;
            end
          end
        end
        EMIT:
          if (res_ready) begin
            res_valid  <= 1'b0;
            done       <= rx_last;
            char_count <= rx_last ? '0 : char_count + 1'b1;
            state      <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: doc/regex_stream_driver.md
# regex_stream_driver

Sequencing stage directly upstream of `compiled_regex`. Accepts a byte stream over valid/ready, buffers it, and runs one matcher evaluation per character: restart pulse, hold character, wait for `rdy`, capture result. Matches are forwarded downstream as start/end position records, and a final `last` evaluation closes each stream. Replaces the behavioural per-character sequencing used in simulation with synthesizable RTL.

## Interface
- `FIFO_DEPTH`, 4, input buffer entries (power of two, ≥2)
- `POS_W`, 32, width of position and count fields
- `RESTART_CYCLES`, 2, cycles `rx_reset` is held high per evaluation (≥1)

- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset for this block
- `in_valid`  in  1  input beat valid
- `in_ready`  out  1  FIFO can accept a beat
- `in_char`  in  8  character; ignored when `in_last`=1
- `in_last`  in  1  beat is end-of-stream marker
- `rx_reset`  out  1  active-high restart to matcher `reset`
- `rx_char`  out  8  to matcher `char`
- `rx_last`  out  1  to matcher `last`
- `rx_rdy`  in  1  matcher `rdy`
- `rx_match`  in  1  matcher `match`
- `rx_start`  in  POS_W  matcher `startPos`
- `rx_end`  in  POS_W  matcher `endPos`
- `res_valid`  out  1  match record valid
- `res_ready`  in  1  downstream accepts record
- `res_start`, `res_end`  out  POS_W  captured positions
- `res_last`  out  1  record came from end-of-stream evaluation
- `done`  out  1  one-cycle pulse when end-of-stream evaluation completes
- `char_count`  out  POS_W  characters evaluated in current stream

## Operation
- Input: beat written as {in_last, in_char} when `in_valid && in_ready`; `in_ready` = !fifo_full.
- FSM states: IDLE, RESTART, WAIT_RDY, EMIT.
  - IDLE: FIFO non-empty → pop head, load `rx_char`/`rx_last`, go RESTART. Otherwise stay.
  - RESTART: `rx_reset`=1 for exactly RESTART_CYCLES cycles → WAIT_RDY.
  - WAIT_RDY: `rx_reset`=0. `rx_rdy` ignored on first WAIT_RDY cycle (stale-ready guard), sampled from second onward. Sampled `rx_rdy`=1: if `rx_match` latch `rx_start`/`rx_end`/`rx_last` into `res_*`, go EMIT; else go IDLE.
  - EMIT: `res_valid`=1, `res_*` stable until `res_ready`; on handshake → IDLE.
- `rx_char`/`rx_last` held stable from RESTART entry until next pop.
- `char_count` increments by 1 when a non-last evaluation completes; wraps modulo 2^POS_W. Cleared the cycle after a last evaluation completes.
- Last evaluation complete (WAIT_RDY exit, or EMIT handshake if matched): `done`=1 for one cycle.
- No timeout; WAIT_RDY waits indefinitely.

## Timing
- Reset asserted: FSM=IDLE, FIFO empty, `rx_reset`=1, `in_ready`=0, `rx_char`=0, `rx_last`=0, `res_valid`=0, `res_*`=0, `done`=0, `char_count`=0. `in_ready`=1 from first edge after deassertion.
- Beat accepted at edge t → pop in IDLE at t+1 → `rx_reset` high t+2..t+1+RESTART_CYCLES → earliest `rx_rdy` sample at t+3+RESTART_CYCLES.
- Matched: `res_valid` rises the cycle after the sample. Not matched: IDLE the cycle after the sample; next pop earliest one cycle later.
- Simultaneous push and pop on a full FIFO: pop frees the slot only next cycle; `in_ready` stays 0 that cycle.
- Reset mid-evaluation: abandons it immediately, FIFO flushed, `rx_reset` re-asserted; no partial record or `done`.

## Structure
- Package `regex_stream_pkg`: state enum, FIFO entry typedef {last, char}, default POS_W.
- Sub-module `byte_fifo` (parameterised depth/width, full/empty, same clk/reset); FSM and capture registers in top.

## Test plan
- Push 'a' (0x61); model matcher asserts `rx_rdy`, `rx_match`=1, start=0, end=1 → one record 0/1, `res_last`=0, `rx_reset` high exactly 2 cycles.
- Push 'b' with `rx_match`=0 → no `res_valid`, `char_count`=1, FSM back to IDLE.
- Match with `res_ready` low 5 cycles → `res_valid` and `res_start`/`res_end` held stable 5 cycles, no new pop.
- Stall matcher (`rx_rdy`=0), push 6 beats with FIFO_DEPTH=4 → `in_ready` falls after 4th buffered beat, no beat lost, order preserved.
- Stream "ab" then last marker, last evaluation matches 0/2 → record `res_last`=1, `done` pulse one cycle, `char_count` 2 then 0.
- Assert reset in WAIT_RDY → `rx_reset`=1, `res_valid`=0, FIFO empty; after release, new beat processed normally.
